// File: rtl/ifdef_stack_tracker.sv
// rtl/ifdef_stack_tracker.sv - nesting tracker for `ifdef/`ifndef/`else/`endif token streams
// Holds per-level {cond, parent-active, else-seen} and flags structural errors into a sticky ERR state.
module ifdef_stack_tracker #(
    parameter int MAX_DEPTH = 8,
    parameter int DEPTH_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tok_valid,
    output logic               tok_ready,
    input  logic [1:0]         tok_op,
    input  logic               tok_defined,
    input  logic               eof,
    output logic               active,
    output logic [DEPTH_W-1:0] depth,
    output logic [2:0]         code,
    output logic               err,
    output logic [2:0]         err_code
);
    localparam int IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

    typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_t;

    state_t               state, state_nxt;
    logic [MAX_DEPTH-1:0] cond_q, par_q, else_q;
    logic [MAX_DEPTH-1:0] cond_d, par_d, else_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d, depth_m1;
    logic                 err_q, err_d;
    logic [2:0]           ec_q, ec_d, tok_ec;
    logic [IDX_W-1:0]     push_idx, top_idx;
    logic                 accept;

    assign depth_m1 = depth_q - DEPTH_W'(1);
    assign push_idx = depth_q[IDX_W-1:0];
    assign top_idx  = depth_m1[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cond_q  <= '0;
            par_q   <= '0;
            else_q  <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            ec_q    <= 3'b000;
        end else begin
            cond_q  <= cond_d;
            par_q   <= par_d;
            else_q  <= else_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            ec_q    <= ec_d;
        end
    end

    // Stack update; an erroring token leaves the stack untouched.
    always_comb begin
        cond_d  = cond_q;
        par_d   = par_q;
        else_d  = else_q;
        depth_d = depth_q;
        tok_ec  = 3'b000;
        accept  = tok_valid && (state == RUN);
        if (accept) begin
            case (tok_op)
                2'b00, 2'b01: begin
                    if (depth_q == MAX_D) begin
                        tok_ec = 3'b001;
                    end else begin
                        cond_d[push_idx] = tok_op[0] ^ tok_defined;
                        par_d[push_idx]  = active;
                        else_d[push_idx] = 1'b0;
                        depth_d          = depth_q + DEPTH_W'(1);
                    end
                end
                2'b10: begin
                    if (depth_q == '0) begin
                        tok_ec = 3'b010;
                    end else if (else_q[top_idx]) begin
                        tok_ec = 3'b011;
                    end else begin
                        cond_d[top_idx] = ~cond_q[top_idx];
                        else_d[top_idx] = 1'b1;
                    end
                end
                default: begin
                    if (depth_q == '0) tok_ec = 3'b010;
                    else               depth_d = depth_m1;
                end
            endcase
        end
    end

    // eof is judged against the depth after this cycle's token.
    always_comb begin
        state_nxt = state;
        err_d     = err_q;
        ec_d      = ec_q;
        if (state == RUN) begin
            if (tok_ec != 3'b000) begin
                state_nxt = ERR;
                err_d     = 1'b1;
                ec_d      = tok_ec;
            end else if (eof && (depth_d != '0)) begin
                state_nxt = ERR;
                err_d     = 1'b1;
                ec_d      = 3'b100;
            end
        end
    end

    always_comb begin
        tok_ready = (state == RUN);
        depth     = depth_q;
        err       = err_q;
        err_code  = ec_q;
        active    = (depth_q == '0) ? 1'b1 : (par_q[top_idx] & cond_q[top_idx]);
        code[2]   = (depth_q > DEPTH_W'(0)) ? cond_q[0] : 1'b0;
        code[1]   = (depth_q > DEPTH_W'(1)) ? cond_q[1] : 1'b0;
        code[0]   = (depth_q > DEPTH_W'(2)) ? cond_q[2] : 1'b0;
    end
endmodule
